// File: rtl/prefix_carry_stage.sv
// Kogge-Stone carry resolution and modular sum select for the 7-bit adder (plain and primed sets).
// Latency: 4 cycles from accept to out_valid; one transfer per cycle when unstalled.
// Backpressure: per-stage valid/ready chain; empty stages still accept, a full pipe drops in_ready.
module prefix_carry_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] carry_generate_vector,
    input  logic [6:0] carry_propagate_vector,
    input  logic [6:0] half_sum_vector,
    input  logic [6:0] g_prim,
    input  logic [6:0] p_prim,
    input  logic [6:0] h_prim,
    input  logic       msb_extra,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] result,
    output logic       sel,
    output logic [2:0] occupancy
);

    typedef struct packed {
        logic [6:0] g;
        logic [6:0] p;
        logic [6:0] h;
    } gph_t;

    // Bits below the span have no lower neighbour: shifting in zeros keeps G,
    // and the low mask keeps P unchanged there.
    function automatic gph_t ks_level(input gph_t x, input int span);
        gph_t y;
        y   = x;
        y.g = x.g | (x.p & (x.g << span));
        y.p = x.p & ((x.p << span) | ~(7'h7F << span));
        return y;
    endfunction

    function automatic logic [6:0] ks_gen(input gph_t x, input int span);
        return x.g | (x.p & (x.g << span));
    endfunction

    gph_t       in_a, in_b;
    gph_t       s1_a, s1_b, s2_a, s2_b;
    logic [6:0] s3_ca, s3_cb, s3_ha, s3_hb;
    logic       m1, m2, m3;
    logic       v1, v2, v3, v4;
    logic       rdy1, rdy2, rdy3, rdy4;
    logic       v1_n, v2_n, v3_n, v4_n;
    logic [6:0] result_q;
    logic       sel_q;
    logic [2:0] occ_q;
    logic [6:0] sum0, sum1, res_n;
    logic       sel_n;

    assign in_a = {carry_generate_vector, carry_propagate_vector, half_sum_vector};
    assign in_b = {g_prim, p_prim, h_prim};

    assign rdy4     = ~v4 | out_ready;
    assign rdy3     = ~v3 | rdy4;
    assign rdy2     = ~v2 | rdy3;
    assign rdy1     = ~v1 | rdy2;
    assign in_ready = rdy1;

    assign v1_n = rdy1 ? in_valid : v1;
    assign v2_n = rdy2 ? v1 : v2;
    assign v3_n = rdy3 ? v2 : v3;
    assign v4_n = rdy4 ? v3 : v4;

    // Group generate over [0..i] is the carry into bit i+1; carry-in is zero.
    always_comb begin
        sum0  = s3_ha ^ {s3_ca[5:0], 1'b0};
        sum1  = s3_hb ^ {s3_cb[5:0], 1'b0};
        sel_n = s3_ca[6] | s3_cb[6] | m3;
        res_n = sel_n ? sum1 : sum0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            v4       <= 1'b0;
            occ_q    <= 3'd0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_a     <= '0;
            s2_b     <= '0;
            s3_ca    <= '0;
            s3_cb    <= '0;
            s3_ha    <= '0;
            s3_hb    <= '0;
            m1       <= 1'b0;
            m2       <= 1'b0;
            m3       <= 1'b0;
            result_q <= '0;
            sel_q    <= 1'b0;
        end else begin
            v1    <= v1_n;
            v2    <= v2_n;
            v3    <= v3_n;
            v4    <= v4_n;
            occ_q <= {2'b0, v1_n} + {2'b0, v2_n} + {2'b0, v3_n} + {2'b0, v4_n};
            if (in_valid && rdy1) begin
                s1_a <= ks_level(in_a, 1);
                s1_b <= ks_level(in_b, 1);
                m1   <= msb_extra;
            end
            if (v1 && rdy2) begin
                s2_a <= ks_level(s1_a, 2);
                s2_b <= ks_level(s1_b, 2);
                m2   <= m1;
            end
            if (v2 && rdy3) begin
                s3_ca <= ks_gen(s2_a, 4);
                s3_cb <= ks_gen(s2_b, 4);
                s3_ha <= s2_a.h;
                s3_hb <= s2_b.h;
                m3    <= m2;
            end
            if (v3 && rdy4) begin
                result_q <= res_n;
                sel_q    <= sel_n;
            end
        end
    end

    assign out_valid = v4;
    assign result    = result_q;
    assign sel       = sel_q;
    assign occupancy = occ_q;

endmodule
